fetch_unit: RTL and testbench

- Instruction fetch stage (F) at the head of the 5-stage F/D/R/E/W pipeline.
- Owns the fetch PC and issues in-order requests to instruction memory over a request/grant + response-valid handshake.
- Buffers returned words in a small prefetch FIFO and presents {instr, pc, valid} to the F/D latch.
- Obeys enable_IFU (stall) and branch_E / branch_target_E (redirect) from pipeline control and Execute.

---
 rtl/fetch_unit.sv | 128 ++++++++++++
 tb/tb_fetch_unit.sv | 278 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/fetch_unit.sv
// Instruction fetch stage: owns the fetch PC, issues in-order imem requests and buffers
// responses in a small prefetch FIFO. Optional same-cycle bypass: define FETCH_BYPASS_EN.
module fetch_unit #(
  parameter int unsigned     XLEN       = 32,
  parameter logic [XLEN-1:0] RESET_PC   = '0,
  parameter int unsigned     FIFO_DEPTH = 2,
  parameter int unsigned     PC_STEP    = 4
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            enable_IFU,
  input  logic            branch_E,
  input  logic [XLEN-1:0] branch_target_E,
  output logic            imem_req,
  output logic [XLEN-1:0] imem_addr,
  input  logic            imem_gnt,
  input  logic            imem_rvalid,
  input  logic [XLEN-1:0] imem_rdata,
  output logic [XLEN-1:0] instr_F,
  output logic [XLEN-1:0] pc_F,
  output logic            valid_F
);

  localparam int unsigned AW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int unsigned CW = $clog2(FIFO_DEPTH + 1);
  localparam logic [CW-1:0] DEPTH_C = CW'(FIFO_DEPTH);
  localparam logic [CW:0]   DEPTH_W = (CW + 1)'(FIFO_DEPTH);

  logic [XLEN-1:0] fetch_pc_q;
  logic [XLEN-1:0] fifo_instr_q [FIFO_DEPTH];
  logic [XLEN-1:0] fifo_pc_q    [FIFO_DEPTH];
  logic [AW-1:0]   fifo_rptr_q, fifo_wptr_q;
  logic [CW-1:0]   fifo_cnt_q;
  logic [XLEN-1:0] pcq_q [FIFO_DEPTH];
  logic [AW-1:0]   pcq_rptr_q, pcq_wptr_q;
  logic [CW-1:0]   outstanding_q, discard_q;
  logic [XLEN-1:0] last_instr_q, last_pc_q;

  logic            fifo_empty, grant, rsp_drop, rsp_take, bypass, push, pop;
  logic [XLEN-1:0] head_instr, head_pc, pcq_head;
  logic [CW:0]     inflight_req, inflight_rsp;

  assign fifo_empty   = (fifo_cnt_q == '0);
  assign inflight_req = {1'b0, fifo_cnt_q} + {1'b0, outstanding_q};
  // Every in-flight response after this cycle, whether already marked for discard or not.
  assign inflight_rsp = {1'b0, discard_q} + {1'b0, outstanding_q} - (CW + 1)'(imem_rvalid);

  assign imem_req  = !rst && !branch_E && (inflight_req < DEPTH_W);
  assign imem_addr = fetch_pc_q;
  assign grant     = imem_req && imem_gnt;

  assign rsp_drop  = imem_rvalid && (discard_q != '0);
  assign rsp_take  = imem_rvalid && (discard_q == '0);
  assign pcq_head  = pcq_q[pcq_rptr_q];

`ifdef FETCH_BYPASS_EN
  assign bypass = !rst && fifo_empty && rsp_take && enable_IFU && !branch_E;
`else
  assign bypass = 1'b0;
`endif

  assign push = rsp_take && !bypass;
  assign pop  = !fifo_empty && !branch_E && enable_IFU;

  // An empty FIFO shows the last consumed word rather than a stale slot.
  assign head_instr = fifo_empty ? last_instr_q : fifo_instr_q[fifo_rptr_q];
  assign head_pc    = fifo_empty ? last_pc_q    : fifo_pc_q[fifo_rptr_q];

  assign valid_F = !rst && !branch_E && (!fifo_empty || bypass);
  assign instr_F = bypass ? imem_rdata : head_instr;
  assign pc_F    = bypass ? pcq_head   : head_pc;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      fetch_pc_q    <= RESET_PC;
      fifo_rptr_q   <= '0;
      fifo_wptr_q   <= '0;
      fifo_cnt_q    <= '0;
      pcq_rptr_q    <= '0;
      pcq_wptr_q    <= '0;
      outstanding_q <= '0;
      discard_q     <= '0;
      last_instr_q  <= '0;
      last_pc_q     <= '0;
      for (int i = 0; i < int'(FIFO_DEPTH); i++) begin
        fifo_instr_q[i] <= '0;
        fifo_pc_q[i]    <= '0;
        pcq_q[i]        <= '0;
      end
    end else if (branch_E) begin
      fetch_pc_q    <= branch_target_E;
      fifo_rptr_q   <= '0;
      fifo_wptr_q   <= '0;
      fifo_cnt_q    <= '0;
      pcq_rptr_q    <= '0;
      pcq_wptr_q    <= '0;
      outstanding_q <= '0;
      discard_q     <= (inflight_rsp > DEPTH_W) ? DEPTH_C : inflight_rsp[CW-1:0];
    end else begin
      if (grant) begin
        fetch_pc_q        <= fetch_pc_q + XLEN'(PC_STEP);
        pcq_q[pcq_wptr_q] <= fetch_pc_q;
        pcq_wptr_q        <= pcq_wptr_q + AW'(1);
      end
      if (rsp_take) begin
        pcq_rptr_q <= pcq_rptr_q + AW'(1);
      end
      if (push) begin
        fifo_instr_q[fifo_wptr_q] <= imem_rdata;
        fifo_pc_q[fifo_wptr_q]    <= pcq_head;
        fifo_wptr_q               <= fifo_wptr_q + AW'(1);
      end
      if (pop) begin
        fifo_rptr_q  <= fifo_rptr_q + AW'(1);
        last_instr_q <= head_instr;
        last_pc_q    <= head_pc;
      end
      if (bypass) begin
        last_instr_q <= imem_rdata;
        last_pc_q    <= pcq_head;
      end
      fifo_cnt_q    <= fifo_cnt_q + CW'(push) - CW'(pop);
      outstanding_q <= outstanding_q + CW'(grant) - CW'(rsp_take);
      discard_q     <= discard_q - CW'(rsp_drop);
    end
  end

endmodule

// File: tb/tb_fetch_unit.sv
// Self-checking bench for fetch_unit: in-order memory model plus an expected-word scoreboard
// filled at each grant and drained as the F/D latch consumes instructions.
module tb_fetch_unit;

  localparam int unsigned XLEN     = 32;
  localparam logic [31:0] RESET_PC = 32'h0000_0000;

  logic        clk, rst, enable_IFU, branch_E, imem_req, imem_gnt, imem_rvalid, valid_F;
  logic [31:0] branch_target_E, imem_addr, imem_rdata, instr_F, pc_F;

  fetch_unit #(
    .XLEN       (XLEN),
    .RESET_PC   (RESET_PC),
    .FIFO_DEPTH (2),
    .PC_STEP    (4)
  ) dut (
    .clk             (clk),
    .rst             (rst),
    .enable_IFU      (enable_IFU),
    .branch_E        (branch_E),
    .branch_target_E (branch_target_E),
    .imem_req        (imem_req),
    .imem_addr       (imem_addr),
    .imem_gnt        (imem_gnt),
    .imem_rvalid     (imem_rvalid),
    .imem_rdata      (imem_rdata),
    .instr_F         (instr_F),
    .pc_F            (pc_F),
    .valid_F         (valid_F)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return (a ^ 32'h5A5A_0F0F) + 32'h0000_0013;
  endfunction

  // Stimulus knobs and model state
  logic        en, br;
  logic [31:0] tgt;
  int          lat;
  bit          rand_gnt;
  logic [63:0] exp_q[$];
  logic [31:0] mem_addr_q[$];
  int          mem_due_q[$];
  logic [31:0] deliv_q[$];
  int          cyc, grants, first_grant_cyc, first_valid_cyc;
  logic [31:0] exp_pc, post_tgt, first_grant_addr, last_gnt_addr;
  bit          post_branch, last_req, last_gnt;

  task automatic clear_model();
    exp_q.delete();
    mem_addr_q.delete();
    mem_due_q.delete();
    deliv_q.delete();
    exp_pc          = RESET_PC;
    post_branch     = 0;
    cyc             = 0;
    grants          = 0;
    first_grant_cyc = -1;
    first_valid_cyc = -1;
    last_gnt        = 0;
  endtask

  // Starts and ends at posedge+1; drives inputs, samples on the falling edge.
  task automatic cycle();
    bit          rv;
    logic [63:0] e;
    enable_IFU      = en;
    branch_E        = br;
    branch_target_E = tgt;
    imem_gnt        = rand_gnt ? ($urandom_range(0, 3) != 0) : 1'b1;
    rv              = (mem_addr_q.size() > 0) && (mem_due_q[0] <= cyc);
    imem_rvalid     = rv;
    imem_rdata      = rv ? mem_word(mem_addr_q[0]) : 32'hDEAD_BEEF;
    @(negedge clk);
    last_gnt = 0;
    if (br) begin
      check_eq("valid_in_branch", 32'(valid_F), 32'd0);
      check_eq("req_in_branch", 32'(imem_req), 32'd0);
      exp_q.delete();
      deliv_q.delete();
      exp_pc      = tgt;
      post_branch = 1;
      post_tgt    = tgt;
    end else if (valid_F && en) begin
      if (first_valid_cyc < 0) first_valid_cyc = cyc;
      if (exp_q.size() == 0) begin
        check_eq("sb_underflow", 32'(valid_F), 32'd0);
      end else begin
        e = exp_q.pop_front();
        check_eq("pc_F", pc_F, e[63:32]);
        check_eq("instr_F", instr_F, e[31:0]);
      end
      if (post_branch) begin
        check_eq("post_branch_pc", pc_F, post_tgt);
        post_branch = 0;
      end
      deliv_q.push_back(pc_F);
    end
    if (rv) begin
      void'(mem_addr_q.pop_front());
      void'(mem_due_q.pop_front());
    end
    if (imem_req && imem_gnt) begin
      check_eq("imem_addr", imem_addr, exp_pc);
      if (first_grant_cyc < 0) begin
        first_grant_cyc  = cyc;
        first_grant_addr = imem_addr;
      end
      exp_q.push_back({exp_pc, mem_word(exp_pc)});
      mem_addr_q.push_back(exp_pc);
      mem_due_q.push_back(cyc + lat);
      last_gnt      = 1;
      last_gnt_addr = exp_pc;
      exp_pc        = exp_pc + 32'd4;
      grants++;
    end
    last_req = imem_req;
    cyc++;
    @(posedge clk);
    #1;
  endtask

  task automatic apply_reset();
    rst         = 1'b1;
    br          = 1'b0;
    en          = 1'b0;
    branch_E    = 1'b0;
    imem_gnt    = 1'b0;
    imem_rvalid = 1'b0;
    #1;
    check_eq("rst_req", 32'(imem_req), 32'd0);
    check_eq("rst_valid", 32'(valid_F), 32'd0);
    check_eq("rst_instr", instr_F, 32'd0);
    check_eq("rst_pc", pc_F, 32'd0);
    clear_model();
    @(posedge clk);
    @(posedge clk);
    #1;
    rst = 1'b0;
  endtask

  task automatic wait_grant(input logic [31:0] a);
    bit found = 0;
    for (int i = 0; i < 40 && !found; i++) begin
      cycle();
      if (last_gnt && last_gnt_addr == a) found = 1;
    end
    check_eq("wait_grant", 32'(found), 32'd1);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    bit   arriving;
    int   pending;
    rst = 1'b1; en = 1'b0; br = 1'b0; tgt = '0; lat = 1; rand_gnt = 0;
    enable_IFU = 1'b0; branch_E = 1'b0; branch_target_E = '0;
    imem_gnt = 1'b0; imem_rvalid = 1'b0; imem_rdata = '0;

    // Sequential fetch, 1-cycle memory
    apply_reset();
    en = 1;
    repeat (12) cycle();
    check_eq("t1_count", 32'(deliv_q.size() >= 4), 32'd1);
    for (int i = 0; i < 4; i++)
      if (i < deliv_q.size()) check_eq($sformatf("t1_pc%0d", i), deliv_q[i], 32'(4 * i));
    check_eq("t1_first_grant", first_grant_addr, RESET_PC);
`ifdef FETCH_BYPASS_EN
    check_eq("t1_latency", 32'(first_valid_cyc - first_grant_cyc), 32'(lat));
`else
    check_eq("t1_latency", 32'(first_valid_cyc - first_grant_cyc), 32'(lat + 1));
`endif

    // Stall: exactly FIFO_DEPTH grants, then hold
    apply_reset();
    en = 0;
    repeat (5) cycle();
    check_eq("t2_grants", 32'(grants), 32'd2);
    check_eq("t2_req_off", 32'(last_req), 32'd0);
    check_eq("t2_valid", 32'(valid_F), 32'd1);
    check_eq("t2_pc_hold", pc_F, 32'h0);
    en = 1;
    repeat (10) cycle();
    for (int i = 0; i < 3; i++)
      if (i < deliv_q.size()) check_eq($sformatf("t2_pc%0d", i), deliv_q[i], 32'(4 * i));

    // Redirect with two late responses in flight
    apply_reset();
    lat = 3;
    en  = 1;
    wait_grant(32'h14);
    br = 1; tgt = 32'h100;
    cycle();
    br = 0;
    repeat (15) cycle();
    check_eq("t3_seen", 32'(deliv_q.size() > 0), 32'd1);
    if (deliv_q.size() > 0) check_eq("t3_first", deliv_q[0], 32'h100);

    // Redirect in the same cycle as the 0x14 response
    apply_reset();
    lat = 1;
    en  = 1;
    wait_grant(32'h14);
    br = 1; tgt = 32'h200;
    cycle();
    br = 0;
    repeat (10) cycle();
    if (deliv_q.size() > 0) check_eq("t4_first", deliv_q[0], 32'h200);

    // Address wrap at the top of the address space
    br = 1; tgt = 32'hFFFF_FFF8;
    cycle();
    br = 0;
    repeat (15) cycle();
    check_eq("t5_count", 32'(deliv_q.size() >= 3), 32'd1);
    if (deliv_q.size() >= 3) begin
      check_eq("t5_pc0", deliv_q[0], 32'hFFFF_FFF8);
      check_eq("t5_pc1", deliv_q[1], 32'hFFFF_FFFC);
      check_eq("t5_pc2", deliv_q[2], 32'h0000_0000);
    end

    // Random stalls, grant throttling and redirects (discard kept within FIFO_DEPTH)
    lat = 2;
    rand_gnt = 1;
    for (int i = 0; i < 300; i++) begin
      pending  = mem_addr_q.size();
      arriving = (pending > 0) && (mem_due_q[0] <= cyc);
      en  = ($urandom_range(0, 3) != 0);
      br  = ($urandom_range(0, 11) == 0) && ((pending - int'(arriving)) <= 2);
      tgt = $urandom & 32'hFFFF_FFFC;
      cycle();
    end
    rand_gnt = 0; br = 0; en = 1;
    repeat (10) cycle();

    // Asynchronous reset with a full FIFO, then with two requests outstanding
    apply_reset();
    lat = 1;
    en  = 0;
    repeat (6) cycle();
    check_eq("t7_full_valid", 32'(valid_F), 32'd1);
    #2;
    apply_reset();
    lat = 3;
    en  = 1;
    repeat (2) cycle();
    check_eq("t7_outstanding", 32'(mem_addr_q.size()), 32'd2);
    #2;
    apply_reset();
    lat = 1;
    en  = 1;
    repeat (8) cycle();
    check_eq("t7_first_grant", first_grant_addr, RESET_PC);
    if (deliv_q.size() > 0) check_eq("t7_first_pc", deliv_q[0], RESET_PC);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
